// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: handshake helper, default widths and the
// stage/opcode enums the CPU pipeline stages are moving onto.
package pipe_pkg;
  localparam int PIPE_DATA_W = 32;

  typedef enum logic [2:0] {
    STAGE_S0,
    STAGE_S1,
    STAGE_S2,
    STAGE_SB3,
    STAGE_WB
  } stage_e;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_SPAWN
  } op_e;

  function automatic logic xfer(input logic valid, input logic ready);
    return valid && ready;
  endfunction
endpackage

// File: rtl/pipe_fork_tracker.sv
// Per-consumer done bits for the head entry of a fork stage; decides
// per-channel valid and when the head has reached every masked consumer.
module pipe_fork_tracker
  import pipe_pkg::*;
#(
  parameter int NUM_OUT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               head_vld,
  input  logic [NUM_OUT-1:0] head_dest,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic               retire
);
  logic [NUM_OUT-1:0] r_done;
  logic [NUM_OUT-1:0] w_xfer;
  logic [NUM_OUT-1:0] w_met;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
    assign out_valid[i] = head_vld && head_dest[i] && !r_done[i] && !flush;
    assign w_xfer[i]    = xfer(out_valid[i], out_ready[i]);
    // A channel is satisfied if it is not a destination, already took the
    // head, or is taking it right now.
    assign w_met[i]     = !head_dest[i] || r_done[i] || w_xfer[i];

    always_ff @(posedge clk) begin
      if (reset || flush || retire) r_done[i] <= 1'b0;
      else if (w_xfer[i])           r_done[i] <= 1'b1;
    end
  end

  assign retire = head_vld && !flush && (&w_met);
endmodule

// File: rtl/pipe_fork_stage.sv
// Ready/valid stage register with a DEPTH-entry buffer that eagerly forks
// each entry to the consumers named in its destination mask.
module pipe_fork_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [NUM_OUT-1:0] in_dest,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [NUM_OUT-1:0] r_dest [DEPTH];
  logic [PTR_W-1:0]   r_head, r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [DATA_W-1:0]  r_last;

  logic w_head_vld, w_push, w_retire;

  assign w_head_vld = (r_count != '0);
  // Ready comes from registered occupancy only, so a pop never frees a slot
  // for the same cycle.
  assign in_ready   = (r_count < DEPTH_C) && !reset;
  assign w_push     = xfer(in_valid, in_ready) && !flush && (|in_dest);
  assign count      = r_count;
  assign out_data   = w_head_vld ? r_data[r_head] : r_last;

  pipe_fork_tracker #(.NUM_OUT(NUM_OUT)) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .head_vld  (w_head_vld),
    .head_dest (r_dest[r_head]),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .retire    (w_retire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_dest[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      r_last <= out_data;
      if (flush) begin
        r_count <= '0;
        r_tail  <= r_head;
      end else begin
        if (w_push) begin
          r_data[r_tail] <= in_data;
          r_dest[r_tail] <= in_dest;
          r_tail         <= r_tail + PTR_W'(1);
        end
        if (w_retire) r_head <= r_head + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_retire);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    r_count <= DEPTH_C);
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    (r_count == '0) |-> !w_retire);
endmodule

// File: tb/tb_pipe_fork_stage.sv
// Directed bench for pipe_fork_stage (NUM_OUT=2, DEPTH=2).
module tb_pipe_fork_stage;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    in_dest, out_valid, out_ready;
  logic [1:0]    count;

  int checks = 0;
  int errors = 0;

  pipe_fork_stage #(.DATA_W(DW), .NUM_OUT(2), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_data = '0; in_dest = '0; flush = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); out_ready = '0;
    tick(); tick();
    checks++; if (count !== 2'd0)    begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL rst_valid: got %b exp 00", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    reset = 0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_basic_fork();
    in_valid = 1; in_data = 32'hA5; in_dest = 2'b11; out_ready = 2'b11; #1;
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL basic_no_bypass: got %b exp 00", out_valid); end
    tick(); idle(); #1;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL basic_count1: got %0d exp 1", count); end
    checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL basic_valid: got %b exp 11", out_valid); end
    checks++; if (out_data !== 32'hA5) begin errors++; $display("FAIL basic_data: got %h exp a5", out_data); end
    tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL basic_count0: got %0d exp 0", count); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL basic_valid0: got %b exp 00", out_valid); end
    checks++; if (out_data !== 32'hA5) begin errors++; $display("FAIL basic_hold: got %h exp a5", out_data); end
  endtask

  task automatic test_staggered();
    logic [1:0] exp_v [4] = '{2'b11, 2'b10, 2'b10, 2'b10};
    int ch0_xfers = 0;
    in_valid = 1; in_data = 32'h11; in_dest = 2'b11; out_ready = 2'b01;
    tick(); idle();
    for (int c = 0; c < 4; c++) begin
      out_ready = (c < 3) ? 2'b01 : 2'b10; #1;
      checks++; if (out_valid !== exp_v[c]) begin errors++; $display("FAIL stag_valid[%0d]: got %b exp %b", c, out_valid, exp_v[c]); end
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL stag_count[%0d]: got %0d exp 1", c, count); end
      if (out_valid[0] && out_ready[0]) ch0_xfers++;
      tick();
    end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL stag_retire: got count %0d exp 0", count); end
    checks++; if (ch0_xfers != 1) begin errors++; $display("FAIL stag_ch0_once: got %0d exp 1", ch0_xfers); end
  endtask

  task automatic test_full();
    out_ready = 2'b00;
    in_valid = 1; in_dest = 2'b01; in_data = 32'h1; tick();
    in_data = 32'h2; tick();
    in_data = 32'h3; #1;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_count: got %0d exp 2", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", in_ready); end
    tick();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_stall: got %0d exp 2", count); end
    idle(); out_ready = 2'b01; #1;
    checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL full_first: got %h exp 1", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_retire: got %b exp 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b exp 1", in_ready); end
    checks++; if (out_data !== 32'h2) begin errors++; $display("FAIL full_second: got %h exp 2", out_data); end
    tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL full_drain: got %0d exp 0", count); end
    out_ready = 2'b00;
  endtask

  task automatic test_wrap();
    int tx = 0, rx = 0;
    logic tog = 1'b0;
    for (int c = 0; c < 60 && rx < 10; c++) begin
      in_valid = (tx < 10); in_data = DW'(tx); in_dest = 2'b10;
      out_ready = {tog, 1'b0}; tog = ~tog; #1;
      if (in_valid && in_ready) tx++;
      if (out_valid[1] && out_ready[1]) begin
        checks++; if (out_data !== DW'(rx)) begin errors++; $display("FAIL wrap_order[%0d]: got %h exp %h", rx, out_data, rx); end
        rx++;
      end
      if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL wrap_ch0: got %b exp 0", out_valid[0]); end
      if (count > 2'd2) begin errors++; $display("FAIL wrap_count: got %0d exp <=2", count); end
      tick();
    end
    idle(); out_ready = 2'b00;
    checks++; if (rx != 10) begin errors++; $display("FAIL wrap_total: got %0d exp 10", rx); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL wrap_empty: got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    out_ready = 2'b00;
    in_valid = 1; in_dest = 2'b11; in_data = 32'h21; tick();
    in_data = 32'h22; tick(); idle();
    out_ready = 2'b01; #1;
    checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL flush_pre: got %b exp 11", out_valid); end
    tick(); out_ready = 2'b00; #1;
    checks++; if (out_valid !== 2'b10) begin errors++; $display("FAIL flush_done0: got %b exp 10", out_valid); end
    flush = 1; in_valid = 1; in_data = 32'h7; in_dest = 2'b11; out_ready = 2'b11; #1;
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_mask: got %b exp 00", out_valid); end
    tick(); idle(); out_ready = 2'b00; #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d exp 0", count); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_after: got %b exp 00", out_valid); end
    // flush with room to accept: the push must still be discarded
    flush = 1; in_valid = 1; in_data = 32'h7; in_dest = 2'b01; tick(); idle(); #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_push: got %0d exp 0", count); end
    in_valid = 1; in_data = 32'h33; in_dest = 2'b11; tick(); idle(); #1;
    checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL flush_reuse_valid: got %b exp 11", out_valid); end
    checks++; if (out_data !== 32'h33) begin errors++; $display("FAIL flush_reuse_data: got %h exp 33", out_data); end
    out_ready = 2'b11; tick(); out_ready = 2'b00;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_reuse_retire: got %0d exp 0", count); end
  endtask

  task automatic test_null_and_reset();
    in_valid = 1; in_data = 32'h55; in_dest = 2'b00; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL null_ready: got %b exp 1", in_ready); end
    tick(); idle(); #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL null_count: got %0d exp 0", count); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL null_valid: got %b exp 00", out_valid); end
    in_valid = 1; in_dest = 2'b01; in_data = 32'h61; tick();
    in_data = 32'h62; tick(); idle(); #1;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL mid_pre: got %0d exp 2", count); end
    reset = 1; tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL mid_count: got %0d exp 0", count); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL mid_valid: got %b exp 00", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_data: got %h exp 0", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b exp 0", in_ready); end
    reset = 0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_fork();
    test_staggered();
    test_full();
    test_wrap();
    test_flush();
    test_null_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
